s420_count_state_reg: RTL

//  Sequential state stage for the s420_1 combinational core. Holds the 16-bit X

---
 rtl/s420_count_state_reg.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/s420_count_state_reg.sv
// -----------------------------------------------------------------------------
// s420_count_state_reg
//
// Sequential state stage for the s420_1 combinational core. Holds the X counter
// state (x_q[0] = X_1 ... x_q[WIDTH-1] = X_16) and the compare constant
// (C_1..C_16). The counter steps under p_0. The stage also registers the
// unsigned compare x_q >= c_q, an all-ones-to-zero wrap pulse, and a saturating
// count of compare rising edges. The compare constant is loaded through a
// valid/ready handshake. After each accepted load, a one-cycle settle window
// lets z_q pick up the new constant before another load is taken.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   p_0        in   1        count enable, +1 per cycle while high
//   clr        in   1        synchronous clear of x_q (has priority over p_0)
//   c_valid    in   1        compare-constant load request
//   c_ready    out  1        compare-constant load ready (high in IDLE)
//   c_data     in   WIDTH    new compare constant
//   x_q        out  WIDTH    counter state
//   c_q        out  WIDTH    current compare constant
//   z_q        out  1        registered x_q >= c_q (unsigned, pre-edge values)
//   wrap_p     out  1        one-cycle pulse on an all-ones -> zero step
//   match_cnt  out  MCNT_W   saturating count of z_q rising edges
// -----------------------------------------------------------------------------
module s420_count_state_reg #(
    parameter int WIDTH  = 16,
    parameter int MCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_0,
    input  logic              clr,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [WIDTH-1:0]  c_data,
    output logic [WIDTH-1:0]  x_q,
    output logic [WIDTH-1:0]  c_q,
    output logic              z_q,
    output logic              wrap_p,
    output logic [MCNT_W-1:0] match_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } load_state_t;

    localparam logic [WIDTH-1:0]  X_ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  X_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  X_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MCNT_W-1:0] MCNT_ZERO  = {MCNT_W{1'b0}};
    localparam logic [MCNT_W-1:0] MCNT_MAX   = {MCNT_W{1'b1}};
    localparam logic [MCNT_W-1:0] MCNT_ONE   = {{(MCNT_W-1){1'b0}}, 1'b1};

    load_state_t       state_q;
    load_state_t       state_d;
    logic              load_accept_s;
    logic              c_ready_s;
    logic [WIDTH-1:0]  x_d;
    logic [WIDTH-1:0]  c_d;
    logic              z_d;
    logic              wrap_d;
    logic              z_prev_q;
    logic              z_prev_d;
    logic [MCNT_W-1:0] match_cnt_d;

    // Load FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load FSM next state. A load is accepted only in IDLE. That is the same
    // condition as c_valid & c_ready, because c_ready is high only in IDLE.
    always_comb begin
        state_d       = state_q;
        load_accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (c_valid) begin
                    load_accept_s = 1'b1;
                    state_d       = ST_SETTLE;
                end else begin
                    state_d       = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Load FSM outputs. c_ready depends only on the state flop, so no input
    // reaches it combinationally.
    always_comb begin
        c_ready_s = 1'b0;
        case (state_q)
            ST_IDLE:   c_ready_s = 1'b1;
            ST_SETTLE: c_ready_s = 1'b0;
            default:   c_ready_s = 1'b0;
        endcase
    end

    assign c_ready = c_ready_s;

    // Counter, wrap pulse and compare-constant next values. clr beats p_0, so
    // a clear on the all-ones step suppresses the wrap pulse.
    always_comb begin
        x_d    = x_q;
        wrap_d = 1'b0;
        if (clr) begin
            x_d    = X_ZERO;
            wrap_d = 1'b0;
        end else if (p_0) begin
            x_d    = x_q + X_ONE;
            wrap_d = (x_q == X_ALL_ONES);
        end else begin
            x_d    = x_q;
            wrap_d = 1'b0;
        end

        c_d = c_q;
        if (load_accept_s) begin
            c_d = c_data;
        end else begin
            c_d = c_q;
        end
    end

    // Compare and match statistics. The compare uses pre-edge x_q/c_q. A load
    // that lands on the same edge therefore affects z_q only one edge later.
    // Rising edges are detected against a delayed copy of z_q.
    always_comb begin
        z_d         = (x_q >= c_q);
        z_prev_d    = z_q;
        match_cnt_d = match_cnt;
        if (z_q && !z_prev_q && (match_cnt != MCNT_MAX)) begin
            match_cnt_d = match_cnt + MCNT_ONE;
        end else begin
            match_cnt_d = match_cnt;
        end
    end

    // Datapath registers. All outputs come straight from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= X_ZERO;
            c_q       <= X_ZERO;
            z_q       <= 1'b0;
            z_prev_q  <= 1'b0;
            wrap_p    <= 1'b0;
            match_cnt <= MCNT_ZERO;
        end else begin
            x_q       <= x_d;
            c_q       <= c_d;
            z_q       <= z_d;
            z_prev_q  <= z_prev_d;
            wrap_p    <= wrap_d;
            match_cnt <= match_cnt_d;
        end
    end

endmodule
